if_fetch: RTL

- Instruction-fetch stage that sits directly upstream of the memory controller (mct).
- Owns the PC and drives the mct instruction port (if_a out; if_n/if_ok in).
- Delivers {pc, instruction} words to decode with a valid/stall handshake.
- Accepts branch redirects from execute; squashes wrong-path fetches.

---
 rtl/if_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the mct fetch port, hands {pc, inst} to decode.
// Defining ICACHE_EN adds a direct-mapped I-cache of ICACHE_LINES words in front of mct.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] if_a,
  input  logic [31:0] if_n,
  input  logic        if_ok,
  input  logic        br_e,
  input  logic [31:0] br_a,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  typedef enum logic [1:0] {
    ST_GUARD = 2'd0,
    ST_WAIT  = 2'd1,
    ST_NEXT  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] redir_a_r;
  logic        redir_pend_r;
  logic        squash_r;

  logic [31:0] br_tgt_s;
  logic [31:0] seq_pc_s;
  logic [31:0] next_pc_s;
  logic [31:0] cache_data_s;
  logic        hold_s;
  logic        held_hit_s;
  logic        cache_hit_s;
  logic        fill_s;
  logic        unused_s;

  assign br_tgt_s  = {br_a[31:2], 2'b00};
  assign seq_pc_s  = redir_pend_r ? redir_a_r : (pc_r + 32'd4);
  assign next_pc_s = br_e ? br_tgt_s : seq_pc_s;
  assign hold_s    = id_valid & id_stall & ~br_e;
  // mct never re-fetches an unchanged if_a, so a target equal to if_a is already on if_n.
  assign held_hit_s = (next_pc_s == if_a);
  assign fill_s     = (state_r == ST_WAIT) & if_ok & ~squash_r;
  assign unused_s   = ^{br_a[1:0], fill_s, 32'(ICACHE_LINES)};

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);

  logic [31:0]         line_data_r [ICACHE_LINES];
  logic [29-IDX_W:0]   line_tag_r  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] line_vld_r;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [IDX_W-1:0]    wr_idx_s;

  assign rd_idx_s     = next_pc_s[IDX_W+1:2];
  assign wr_idx_s     = if_a[IDX_W+1:2];
  assign cache_hit_s  = line_vld_r[rd_idx_s] & (line_tag_r[rd_idx_s] == next_pc_s[31:IDX_W+2]);
  assign cache_data_s = line_data_r[rd_idx_s];

  // Line valid bits, cleared by reset and set on every non-squashed fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_vld_r <= {ICACHE_LINES{1'b0}};
    end else if (fill_s) begin
      line_vld_r[wr_idx_s] <= 1'b1;
    end
  end

  // Line data and tag storage, written alongside the valid bit.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      line_data_r[wr_idx_s] <= if_n;
      line_tag_r[wr_idx_s]  <= if_a[31:IDX_W+2];
    end
  end
`else
  assign cache_hit_s  = 1'b0;
  assign cache_data_s = 32'h0000_0000;
`endif

  // Fetch sequencer: GUARD masks the stale if_ok, WAIT collects the word, NEXT delivers and issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_WAIT;
      if_a         <= RESET_PC;
      pc_r         <= RESET_PC;
      redir_a_r    <= 32'h0000_0000;
      redir_pend_r <= 1'b0;
      squash_r     <= 1'b0;
      id_valid     <= 1'b0;
      id_inst      <= 32'h0000_0000;
      id_pc        <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_GUARD: begin
          if (br_e) begin
            redir_pend_r <= 1'b1;
            redir_a_r    <= br_tgt_s;
            squash_r     <= 1'b1;
            id_valid     <= 1'b0;
          end
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (br_e) begin
            redir_pend_r <= 1'b1;
            redir_a_r    <= br_tgt_s;
            id_valid     <= 1'b0;
            // A word arriving with the redirect is itself the discarded one.
            if (if_ok) begin
              squash_r <= 1'b0;
              state_r  <= ST_NEXT;
            end else begin
              squash_r <= 1'b1;
            end
          end else if (if_ok) begin
            if (squash_r) begin
              squash_r <= 1'b0;
            end else begin
              id_inst  <= if_n;
              id_pc    <= if_a;
              id_valid <= 1'b1;
            end
            state_r <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (hold_s) begin
            state_r <= ST_NEXT;
          end else if (held_hit_s) begin
            id_inst      <= if_n;
            id_pc        <= next_pc_s;
            id_valid     <= 1'b1;
            pc_r         <= next_pc_s;
            redir_pend_r <= 1'b0;
          end else if (cache_hit_s) begin
            id_inst      <= cache_data_s;
            id_pc        <= next_pc_s;
            id_valid     <= 1'b1;
            pc_r         <= next_pc_s;
            redir_pend_r <= 1'b0;
          end else begin
            id_valid     <= 1'b0;
            if_a         <= next_pc_s;
            pc_r         <= next_pc_s;
            redir_pend_r <= 1'b0;
            state_r      <= ST_GUARD;
          end
        end
        default: begin
          state_r  <= ST_WAIT;
          id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
